led_flow_decoder: RTL and testbench
===================================

# led_flow_decoder

Receive-side decoder for the 8-bit running-light bus. Samples the one-hot LED pattern on a sample strobe, and recovers:
- the lit position;
- the shift direction;
- a step count;
- protocol errors (non-one-hot pattern or illegal jump).

Sits on the far end of the LED bus from the flow-light controller and shares its clock and baud-tick strobe. Used as an on-board checker and as the observer feeding status LEDs/segments.

## Interface
Parameters:
- CNT_W, 16, width of step counter (saturating)

Ports:
- clk  input  1  system clock, all logic rising-edge
- rst_n  input  1  synchronous, active-low reset
- led_in  input  8  observed LED pattern, bit i = LED i
- sample_en  input  1  one-cycle strobe; the pattern is evaluated only in cycles with sample_en=1
- clr  input  1  synchronous clear of error/tracking state (returns to IDLE)
- pos  output  3  index of lit LED in last valid sample
- pos_valid  output  1  pos holds a decoded value
- dir  output  1  0 = shifting up (bit i→i+1, 7→0), 1 = shifting down (bit i→i−1, 0→7)
- dir_valid  output  1  dir has been established
- dir_chg  output  1  one-cycle pulse when direction reverses
- step_cnt  output  CNT_W  count of legal steps since IDLE
- err  output  1  sticky error flag
- err_code  output  2  0 none, 1 not one-hot, 2 illegal jump

## Operation
- Sample is legal if exactly one bit is set. Let P = previous legal sample. Define up(P) = rotate-left-by-1 of P, and dn(P) = rotate-right-by-1 of P.
- States: IDLE, LOCK, TRACK, ERR. Only sample_en cycles cause transitions; clr has priority.
- IDLE:
  - legal sample → LOCK; set pos and pos_valid=1.
  - non-one-hot → ERR; err_code=1.
- LOCK:
  - same pattern → stay, no count.
  - up(P) → TRACK; dir=0, dir_valid=1, step_cnt=1.
  - dn(P) → TRACK; dir=1, dir_valid=1, step_cnt=1.
  - non-one-hot → ERR, code 1.
  - any other pattern → ERR, code 2.
- TRACK:
  - same pattern → hold, no count.
  - step in current dir → step_cnt+1.
  - step in opposite dir → dir toggles, dir_chg=1 for one cycle, step_cnt+1.
  - non-one-hot → ERR, code 1.
  - other → ERR, code 2.
- ERR:
  - err=1 and err_code are sticky.
  - pos, dir and step_cnt freeze at their last legal values.
  - Further samples are ignored.
  - Leave only via clr or reset.
- clr (any state): next state IDLE; all outputs return to reset values. If clr and sample_en occur in the same cycle, that sample is discarded.
- step_cnt saturates at 2^CNT_W−1, with no wrap. Direction tracking continues while saturated.
- Wrap-around is a legal step in both directions: 0x80→0x01 is up; 0x01→0x80 is down.

## Timing
- All outputs registered. Latency: outputs reflect a sample one clk after the sample_en edge (plus the synchronizer delay if enabled).
- Reset values:
  - state = IDLE
  - pos = 0, pos_valid = 0, dir = 0, dir_valid = 0, dir_chg = 0
  - step_cnt = 0, err = 0, err_code = 0
- Reset asserted mid-tracking takes effect at the next edge and overrides clr and sample_en.
- dir_chg is high for exactly one clk per reversal, even when sample_en pulses are back-to-back.
- led_in is don't-care in cycles without sample_en.

## Configuration
- LED_DEC_SYNC_EN defined:
  - led_in passes through a 2-flop synchronizer before decoding. Both synchronizer flops reset to 0 on rst_n.
  - sample_en is delayed by 2 cycles to stay aligned, so end-to-end latency is 3 clk.
  - Use when led_in comes from pins or another clock domain.
- Undefined: led_in is decoded directly; latency is 1 clk.

## Test plan
- Reset, then samples 0x01,0x02,0x04 → pos=2, dir=0, dir_valid=1, step_cnt=2, err=0.
- Samples 0x02,0x01,0x80,0x40 → wrap accepted, dir=1, step_cnt=3. Then 0x80 → dir=0, dir_chg pulse of 1 clk, step_cnt=4.
- In TRACK at 0x04, sample 0x06 → err=1, err_code=1. Later legal samples leave pos=2 and step_cnt unchanged.
- In TRACK at 0x04, sample 0x20 → err_code=2. Then clr → all outputs at reset values; next 0x20 → LOCK with pos=5.
- Repeated samples 0x08,0x08,0x08 in TRACK → step_cnt unchanged, no error. With CNT_W=2, five legal steps → step_cnt=3 (saturated).
- clr and sample_en in the same cycle with 0x00 on led_in → IDLE, err=0. With LED_DEC_SYNC_EN defined, the first decode appears 3 clk after sample_en.

Source files
------------

// File: rtl/led_flow_decoder_if.sv
// rtl/led_flow_decoder_if.sv - LED bus interface between flow-light controller and decoder
//   led_in     8  observed one-hot LED pattern, bit i = LED i
//   sample_en  1  one-cycle strobe marking cycles in which led_in is evaluated
//   modports: master drives the bus, slave observes it
interface led_flow_decoder_if;
  logic [7:0] led_in;
  logic       sample_en;

  modport master (output led_in, output sample_en);
  modport slave  (input  led_in, input  sample_en);
endinterface

// File: rtl/led_flow_decoder.sv
// rtl/led_flow_decoder.sv - receive-side decoder for the 8-bit running-light bus
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   bus        in   led_flow_decoder_if.slave (led_in, sample_en)
//   clr        in   synchronous clear back to IDLE, discards a coincident sample
//   pos        out  index of the lit LED in the last legal sample
//   pos_valid  out  pos holds a decoded value
//   dir        out  0 = shifting up, 1 = shifting down
//   dir_valid  out  dir has been established
//   dir_chg    out  one-cycle pulse on direction reversal
//   step_cnt   out  saturating count of legal steps since IDLE
//   err        out  sticky error flag
//   err_code   out  0 none, 1 not one-hot, 2 illegal jump
//   Optional: define LED_DEC_SYNC_EN to pass led_in through a 2-flop
//   synchronizer with sample_en delayed to match (latency 3 clk).
module led_flow_decoder #(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  led_flow_decoder_if.slave     bus,
  input  logic                  clr,
  output logic [2:0]            pos,
  output logic                  pos_valid,
  output logic                  dir,
  output logic                  dir_valid,
  output logic                  dir_chg,
  output logic [CNT_W-1:0]      step_cnt,
  output logic                  err,
  output logic [1:0]            err_code
);

  typedef enum logic [1:0] {IDLE, LOCK, TRACK, ERR} state_t;

  logic [7:0] led_d;
  logic       en;

`ifdef LED_DEC_SYNC_EN
  logic [7:0] led_s1, led_s2;
  logic [1:0] en_d;

  // clr also flushes an in-flight strobe so a sample coincident with clr
  // stays discarded after the pipeline delay.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_s1 <= '0;
      led_s2 <= '0;
      en_d   <= '0;
    end else begin
      led_s1 <= bus.led_in;
      led_s2 <= led_s1;
      en_d   <= clr ? 2'b00 : {en_d[0], bus.sample_en};
    end
  end

  assign led_d = led_s2;
  assign en    = en_d[1];
`else
  assign led_d = bus.led_in;
  assign en    = bus.sample_en;
`endif

  state_t           state, state_n;
  logic [7:0]       prev, prev_n;
  logic [2:0]       pos_n;
  logic             pos_valid_n, dir_n, dir_valid_n, dir_chg_n, err_n;
  logic [CNT_W-1:0] step_cnt_n;
  logic [1:0]       err_code_n;

  logic [7:0] up_p, dn_p;
  logic       one_hot, is_up, is_dn;
  logic [CNT_W-1:0] cnt_inc;

  function automatic logic [2:0] enc(input logic [7:0] v);
    enc = '0;
    for (int i = 0; i < 8; i++)
      if (v[i]) enc = 3'(i);
  endfunction

  // Rotations make the 7->0 / 0->7 wrap a legal step in either direction.
  assign up_p    = {prev[6:0], prev[7]};
  assign dn_p    = {prev[0], prev[7:1]};
  assign one_hot = $onehot(led_d);
  assign is_up   = (led_d == up_p);
  assign is_dn   = (led_d == dn_p);
  assign cnt_inc = (step_cnt == {CNT_W{1'b1}}) ? step_cnt : step_cnt + CNT_W'(1);

  always_comb begin
    state_n     = state;
    prev_n      = prev;
    pos_n       = pos;
    pos_valid_n = pos_valid;
    dir_n       = dir;
    dir_valid_n = dir_valid;
    dir_chg_n   = 1'b0;
    step_cnt_n  = step_cnt;
    err_n       = err;
    err_code_n  = err_code;

    if (clr) begin
      state_n     = IDLE;
      prev_n      = '0;
      pos_n       = '0;
      pos_valid_n = 1'b0;
      dir_n       = 1'b0;
      dir_valid_n = 1'b0;
      step_cnt_n  = '0;
      err_n       = 1'b0;
      err_code_n  = 2'd0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (one_hot) begin
            state_n     = LOCK;
            prev_n      = led_d;
            pos_n       = enc(led_d);
            pos_valid_n = 1'b1;
          end else begin
            state_n    = ERR;
            err_n      = 1'b1;
            err_code_n = 2'd1;
          end
        end
        LOCK, TRACK: begin
          if (led_d == prev) begin
            state_n = state;
          end else if (is_up || is_dn) begin
            state_n     = TRACK;
            prev_n      = led_d;
            pos_n       = enc(led_d);
            dir_n       = is_dn;
            dir_valid_n = 1'b1;
            if (state == LOCK) begin
              step_cnt_n = CNT_W'(1);
            end else begin
              step_cnt_n = cnt_inc;
              dir_chg_n  = (is_dn != dir);
            end
          end else begin
            state_n    = ERR;
            err_n      = 1'b1;
            err_code_n = one_hot ? 2'd2 : 2'd1;
          end
        end
        default: state_n = ERR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      prev      <= '0;
      pos       <= '0;
      pos_valid <= 1'b0;
      dir       <= 1'b0;
      dir_valid <= 1'b0;
      dir_chg   <= 1'b0;
      step_cnt  <= '0;
      err       <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      state     <= state_n;
      prev      <= prev_n;
      pos       <= pos_n;
      pos_valid <= pos_valid_n;
      dir       <= dir_n;
      dir_valid <= dir_valid_n;
      dir_chg   <= dir_chg_n;
      step_cnt  <= step_cnt_n;
      err       <= err_n;
      err_code  <= err_code_n;
    end
  end

endmodule

// File: tb/tb_led_flow_decoder.sv
// tb/tb_led_flow_decoder.sv - directed self-checking bench for led_flow_decoder
module tb_led_flow_decoder;

`ifdef LED_DEC_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n, clr;

  logic [2:0]  pos, pos2;
  logic        pos_valid, dir, dir_valid, dir_chg, err;
  logic        pos_valid2, dir2, dir_valid2, dir_chg2, err2;
  logic [15:0] step_cnt;
  logic [1:0]  step_cnt2;
  logic [1:0]  err_code, err_code2;

  int n_tests = 0;
  int n_fail  = 0;

  led_flow_decoder_if bus ();

  led_flow_decoder #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .clr(clr),
    .pos(pos), .pos_valid(pos_valid), .dir(dir), .dir_valid(dir_valid),
    .dir_chg(dir_chg), .step_cnt(step_cnt), .err(err), .err_code(err_code)
  );

  led_flow_decoder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus), .clr(clr),
    .pos(pos2), .pos_valid(pos_valid2), .dir(dir2), .dir_valid(dir_valid2),
    .dir_chg(dir_chg2), .step_cnt(step_cnt2), .err(err2), .err_code(err_code2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pos"},       32'(pos),       32'd0);
    chk({tag, "_pos_valid"}, 32'(pos_valid), 32'd0);
    chk({tag, "_dir"},       32'(dir),       32'd0);
    chk({tag, "_dir_valid"}, 32'(dir_valid), 32'd0);
    chk({tag, "_dir_chg"},   32'(dir_chg),   32'd0);
    chk({tag, "_step_cnt"},  32'(step_cnt),  32'd0);
    chk({tag, "_err"},       32'(err),       32'd0);
    chk({tag, "_err_code"},  32'(err_code),  32'd0);
  endtask

  // Drive one sample strobe, then wait until its decode is visible.
  task automatic smp(input logic [7:0] v);
    @(negedge clk);
    bus.led_in    = v;
    bus.sample_en = 1'b1;
    @(negedge clk);
    bus.sample_en = 1'b0;
    repeat (LAT - 1) @(negedge clk);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (LAT) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    clr = 1'b0;
    bus.led_in = 8'h00;
    bus.sample_en = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;

    // Up-shift from LOCK
    smp(8'h01); smp(8'h02); smp(8'h04);
    chk("up_pos",  32'(pos),       32'd2);
    chk("up_dir",  32'(dir),       32'd0);
    chk("up_dv",   32'(dir_valid), 32'd1);
    chk("up_cnt",  32'(step_cnt),  32'd2);
    chk("up_err",  32'(err),       32'd0);

    // Down-shift across the 0->7 wrap, then reversal
    do_clr();
    smp(8'h02); smp(8'h01);
    chk("dn_first_chg", 32'(dir_chg), 32'd0);
    smp(8'h80); smp(8'h40);
    chk("dn_pos",  32'(pos),      32'd6);
    chk("dn_dir",  32'(dir),      32'd1);
    chk("dn_cnt",  32'(step_cnt), 32'd3);
    smp(8'h80);
    chk("rev_dir",  32'(dir),       32'd0);
    chk("rev_chg",  32'(dir_chg),   32'd1);
    chk("rev_cnt",  32'(step_cnt),  32'd4);
    chk("sat_cnt4", 32'(step_cnt2), 32'd3);
    @(negedge clk);
    chk("rev_chg_end", 32'(dir_chg), 32'd0);
    smp(8'h01);
    chk("wrap_up_pos", 32'(pos),       32'd0);
    chk("wrap_up_cnt", 32'(step_cnt),  32'd5);
    chk("wrap_up_chg", 32'(dir_chg),   32'd0);
    chk("sat_cnt5",    32'(step_cnt2), 32'd3);
    chk("sat_dir",     32'(dir2),      32'd0);

    // Non-one-hot in TRACK, then frozen
    do_clr();
    smp(8'h02); smp(8'h04);
    smp(8'h06);
    chk("nh_err",  32'(err),      32'd1);
    chk("nh_code", 32'(err_code), 32'd1);
    smp(8'h08);
    chk("frz_pos",  32'(pos),      32'd2);
    chk("frz_cnt",  32'(step_cnt), 32'd1);
    chk("frz_code", 32'(err_code), 32'd1);

    // Illegal jump, clr, relock
    do_clr();
    chk_reset("clr1");
    smp(8'h02); smp(8'h04);
    smp(8'h20);
    chk("jmp_err",  32'(err),      32'd1);
    chk("jmp_code", 32'(err_code), 32'd2);
    chk("jmp_pos",  32'(pos),      32'd2);
    do_clr();
    chk_reset("clr2");
    smp(8'h20);
    chk("relock_pos", 32'(pos),       32'd5);
    chk("relock_pv",  32'(pos_valid), 32'd1);
    chk("relock_dv",  32'(dir_valid), 32'd0);
    chk("relock_cnt", 32'(step_cnt),  32'd0);

    // Repeated pattern in TRACK holds
    do_clr();
    smp(8'h04); smp(8'h08);
    smp(8'h08); smp(8'h08); smp(8'h08);
    chk("hold_cnt", 32'(step_cnt), 32'd1);
    chk("hold_err", 32'(err),      32'd0);
    chk("hold_pos", 32'(pos),      32'd3);

    // clr with coincident sample of 0x00 discards the sample
    @(negedge clk);
    clr = 1'b1;
    bus.sample_en = 1'b1;
    bus.led_in = 8'h00;
    @(negedge clk);
    clr = 1'b0;
    bus.sample_en = 1'b0;
    repeat (LAT) @(negedge clk);
    chk("clr_smp_err", 32'(err),       32'd0);
    chk("clr_smp_pv",  32'(pos_valid), 32'd0);

    // Decode latency
    @(negedge clk);
    bus.led_in = 8'h01;
    bus.sample_en = 1'b1;
    @(negedge clk);
    bus.sample_en = 1'b0;
    repeat (LAT - 1) begin
      chk("lat_early_pv", 32'(pos_valid), 32'd0);
      @(negedge clk);
    end
    chk("lat_pv", 32'(pos_valid), 32'd1);

    // Non-one-hot in IDLE
    do_clr();
    smp(8'h00);
    chk("idle_nh_err",  32'(err),      32'd1);
    chk("idle_nh_code", 32'(err_code), 32'd1);

    // Illegal jump from LOCK
    do_clr();
    smp(8'h01); smp(8'h04);
    chk("lock_jmp_code", 32'(err_code), 32'd2);
    chk("lock_jmp_dv",   32'(dir_valid), 32'd0);

    // Reset mid-tracking overrides clr and sample_en
    do_clr();
    smp(8'h10); smp(8'h20);
    chk("pre_rst_cnt", 32'(step_cnt), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    clr = 1'b1;
    bus.sample_en = 1'b1;
    bus.led_in = 8'h40;
    @(negedge clk);
    clr = 1'b0;
    bus.sample_en = 1'b0;
    chk_reset("rst_mid");
    rst_n = 1'b1;
    repeat (LAT + 1) @(negedge clk);
    chk_reset("rst_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
